// File: rtl/triangle_packer.sv
// triangle_packer: write-side front end of the triangle FIFO.
// Collects BYTES-byte triangle records from the host-link byte stream and
// pushes each complete record into the FIFO. It also keeps triangle/error
// counters and a registered busy flag for MCU flow control.
//
// Handshake: a byte transfers on a rising edge where in_valid & in_ready are
// both high. Upstream must hold in_byte/in_first stable while in_valid is high
// and in_ready is low. in_ready and fifo_push are combinational from state,
// rst and fifo_full only; they never depend on in_valid.
//
// DATA_W must equal 8*BYTES, and BYTES must be at least 2.

module triangle_packer #(
    parameter int BYTES  = 30,
    parameter int DATA_W = 240
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    input  logic              in_first,
    output logic              in_ready,
    output logic [DATA_W-1:0] fifo_data,
    output logic              fifo_push,
    input  logic              fifo_full,
    input  logic              fifo_almost_full,
    output logic              host_busy,
    output logic [15:0]       tri_count,
    output logic [7:0]        err_count,
    output logic [1:0]        dbg_state
);

    localparam int IDX_W = (BYTES > 2) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_PUSH    = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] idx;
    logic             xfer;
    logic             load;
    logic             shift;
    logic             err_inc;

    assign dbg_state = state;

    // Byte acceptance and FIFO push strobe; both are forced low while reset is asserted.
    always_comb begin
        in_ready  = !rst && (state != S_PUSH);
        fifo_push = !rst && (state == S_PUSH) && !fifo_full;
        xfer      = in_valid && in_ready;
    end

    // Next-state logic plus datapath control strobes.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        shift      = 1'b0;
        err_inc    = 1'b0;
        case (state)
            S_IDLE: begin
                if (xfer) begin
                    if (in_first) begin
                        load       = 1'b1;
                        next_state = S_COLLECT;
                    end else begin
                        // A stray byte with no record open is a framing error.
                        err_inc = 1'b1;
                    end
                end
            end
            S_COLLECT: begin
                if (xfer) begin
                    if (in_first) begin
                        // Resync: drop the partial record and restart on this byte.
                        load    = 1'b1;
                        err_inc = 1'b1;
                    end else begin
                        shift = 1'b1;
                        if (idx == IDX_LAST) begin
                            next_state = S_PUSH;
                        end
                    end
                end
            end
            S_PUSH: begin
                if (fifo_push) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Record shift register and byte index. Data only moves on load or shift,
    // so the record stays stable for the whole time the FSM sits in PUSH.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_data <= '0;
            idx       <= '0;
        end else if (load) begin
            fifo_data <= {{(DATA_W-8){1'b0}}, in_byte};
            idx       <= IDX_W'(1);
        end else if (shift) begin
            fifo_data <= {fifo_data[DATA_W-9:0], in_byte};
            idx       <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end
    end

    // Counters and the registered flow-control flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            tri_count <= '0;
            err_count <= '0;
            host_busy <= 1'b0;
        end else begin
            host_busy <= fifo_almost_full || ((state == S_PUSH) && fifo_full);
            if (fifo_push) begin
                tri_count <= tri_count + 16'd1;
            end
            if (err_inc && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_triangle_packer.sv
// Directed testbench for triangle_packer: a table of frame scenarios plus
// hand-written sequences for back-to-back frames, reset, busy lag and saturation.

module tb_triangle_packer;

    localparam int BYTES  = 30;
    localparam int DATA_W = 240;

    logic              clk;
    logic              rst;
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_first;
    logic              in_ready;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_almost_full;
    logic              host_busy;
    logic [15:0]       tri_count;
    logic [7:0]        err_count;
    logic [1:0]        dbg_state;

    triangle_packer #(.BYTES(BYTES), .DATA_W(DATA_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_byte          (in_byte),
        .in_valid         (in_valid),
        .in_first         (in_first),
        .in_ready         (in_ready),
        .fifo_data        (fifo_data),
        .fifo_push        (fifo_push),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .host_busy        (host_busy),
        .tri_count        (tri_count),
        .err_count        (err_count),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    int push_count = 0;
    int exp_pushes = 0;
    int last_push_cyc = -1;
    logic [DATA_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] make_rec(input logic [7:0] base);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < BYTES; i++) r = {r[DATA_W-9:0], 8'(base + i)};
        return r;
    endfunction

    // Every push must be expected, carry the expected record and avoid a full FIFO.
    always @(negedge clk) begin
        if (fifo_push === 1'b1) begin
            push_count++;
            last_push_cyc = cyc;
            chk("push_while_full", {255'd0, fifo_full}, 256'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_push: got data %0h expected no push", fifo_data);
            end else begin
                chk("push_data", fifo_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end just after a rising edge.
    task automatic send_byte(input logic [7:0] b, input logic first,
                             output int acc_cyc, output int stalls);
        logic ok;
        logic done;
        in_byte  = b;
        in_first = first;
        in_valid = 1'b1;
        stalls   = 0;
        done     = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) done = 1'b1;
            else stalls++;
        end
        if (!done) chk("accept_timeout", 256'd0, 256'd1);
        acc_cyc = cyc;
    endtask

    task automatic send_frame(input logic [7:0] base, input int count,
                              output int last_cyc, output int first_stalls);
        int a;
        int s;
        first_stalls = 0;
        last_cyc = 0;
        for (int i = 0; i < count; i++) begin
            send_byte(8'(base + i), (i == 0), a, s);
            if (i == 0) first_stalls = s;
            last_cyc = a;
        end
    endtask

    task automatic send_junk(input int n);
        int a;
        int s;
        for (int i = 0; i < n; i++) send_byte(8'hEE, 1'b0, a, s);
    endtask

    task automatic wait_push(input int target);
        for (int t = 0; t < 60 && push_count < target; t++) begin
            @(posedge clk);
            #2;
        end
        if (push_count < target) chk("push_timeout", 256'(push_count), 256'(target));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_byte = 8'h00;
        fifo_full = 1'b0;
        fifo_almost_full = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", {255'd0, in_ready}, 256'd0);
        chk("rst_push", {255'd0, fifo_push}, 256'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {255'd0, in_ready}, 256'd1);
        chk("post_rst_data", fifo_data, 256'd0);
        chk("post_rst_push", {255'd0, fifo_push}, 256'd0);
        chk("post_rst_busy", {255'd0, host_busy}, 256'd0);
        chk("post_rst_tri", 256'(tri_count), 256'd0);
        chk("post_rst_err", 256'(err_count), 256'd0);
        chk("post_rst_state", 256'(dbg_state), 256'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]  base;
        int          junk;
        int          trunc;
        int          hold;
        logic [7:0]  exp_err;
        logic [15:0] exp_tri;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v);
        logic [DATA_W-1:0] rec;
        int last;
        int st;
        send_junk(v.junk);
        if (v.trunc > 0) send_frame(8'hA0, v.trunc, last, st);
        rec = make_rec(v.base);
        exp_q.push_back(rec);
        exp_pushes++;
        if (v.hold == 0) begin
            send_frame(v.base, BYTES, last, st);
            in_valid = 1'b0;
            wait_push(exp_pushes);
            chk("push_latency", 256'(last_push_cyc), 256'(last));
        end else begin
            send_frame(v.base, BYTES - 1, last, st);
            fifo_full = 1'b1;
            send_byte(8'(v.base + BYTES - 1), 1'b0, last, st);
            in_valid = 1'b0;
            for (int k = 0; k < v.hold; k++) begin
                @(negedge clk);
                chk("held_push", {255'd0, fifo_push}, 256'd0);
                chk("held_data", fifo_data, rec);
                if (k == 0) chk("busy_lag0", {255'd0, host_busy}, 256'd0);
                if (k == 1) chk("busy_full", {255'd0, host_busy}, 256'd1);
                @(posedge clk);
                #1;
            end
            fifo_full = 1'b0;
            wait_push(exp_pushes);
            chk("release_latency", 256'(last_push_cyc), 256'(last + v.hold));
        end
        chk("push_count", 256'(push_count), 256'(exp_pushes));
        chk("err_count", 256'(err_count), 256'(v.exp_err));
        chk("tri_count", 256'(tri_count), 256'(v.exp_tri));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int last_a;
        int last_b;
        int st;
        logic [DATA_W-1:0] frame1;

        vecs[0] = '{base: 8'h01, junk: 0, trunc: 0,  hold: 0,  exp_err: 8'd0, exp_tri: 16'd1};
        vecs[1] = '{base: 8'h40, junk: 5, trunc: 0,  hold: 0,  exp_err: 8'd5, exp_tri: 16'd2};
        vecs[2] = '{base: 8'h80, junk: 0, trunc: 12, hold: 0,  exp_err: 8'd6, exp_tri: 16'd3};
        vecs[3] = '{base: 8'hC0, junk: 0, trunc: 0,  hold: 10, exp_err: 8'd6, exp_tri: 16'd4};
        vecs[4] = '{base: 8'h11, junk: 2, trunc: 12, hold: 3,  exp_err: 8'd9, exp_tri: 16'd5};

        rst = 1'b1;
        in_byte = 8'h00;
        in_valid = 1'b0;
        in_first = 1'b0;
        fifo_full = 1'b0;
        fifo_almost_full = 1'b0;
        do_reset();

        // Record 0x01..0x1E must land with byte 0 in the top byte.
        frame1 = 240'h0102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E;
        chk("model_frame1", make_rec(8'h01), frame1);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Two frames back to back with in_valid held: exactly one dead cycle.
        exp_q.push_back(make_rec(8'h21));
        exp_q.push_back(make_rec(8'h61));
        exp_pushes += 2;
        send_frame(8'h21, BYTES, last_a, st);
        send_frame(8'h61, BYTES, last_b, st);
        chk("b2b_gap_stalls", 256'(st), 256'd1);
        in_valid = 1'b0;
        wait_push(exp_pushes);
        chk("b2b_push_count", 256'(push_count), 256'(exp_pushes));
        chk("b2b_tri", 256'(tri_count), 256'd7);

        // host_busy follows fifo_almost_full one cycle late.
        fifo_almost_full = 1'b1;
        @(negedge clk);
        chk("af_lag", {255'd0, host_busy}, 256'd0);
        @(posedge clk);
        #1;
        fifo_almost_full = 1'b0;
        @(negedge clk);
        chk("af_busy", {255'd0, host_busy}, 256'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("af_clear", {255'd0, host_busy}, 256'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of a frame discards it without counting an error.
        send_frame(8'h50, 17, last_a, st);
        in_valid = 1'b0;
        do_reset();
        chk("mid_rst_no_push", 256'(push_count), 256'(exp_pushes));
        run_vec('{base: 8'h33, junk: 0, trunc: 0, hold: 0, exp_err: 8'd0, exp_tri: 16'd1});

        // 300 frames, each preceded by a stray byte: errors saturate, triangles count on.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send_junk(1);
            exp_q.push_back(make_rec(8'(i)));
            exp_pushes++;
            send_frame(8'(i), BYTES, last_a, st);
            in_valid = 1'b0;
            wait_push(exp_pushes);
        end
        chk("sat_err", 256'(err_count), 256'd255);
        chk("sat_tri", 256'(tri_count), 256'd300);
        chk("final_queue_empty", 256'(exp_q.size()), 256'd0);
        chk("final_push_count", 256'(push_count), 256'(exp_pushes));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/triangle_packer.md
# triangle_packer

Write-side front end of the triangle FIFO. Assembles 240-bit triangle records from the byte stream delivered by the host-link receiver and pushes each complete record into the triangle FIFO. Provides byte-level backpressure, framing-error recovery and a registered busy flag the host link reports back to the MCU for flow control.

## Interface
- BYTES, 30, bytes per triangle record
- DATA_W, 240, record width; must equal 8*BYTES
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_byte  in  8  incoming byte
- in_valid  in  1  in_byte valid this cycle
- in_first  in  1  in_byte is byte 0 of a triangle; qualified by in_valid
- in_ready  out  1  packer accepts a byte this cycle; transfer = in_valid & in_ready
- fifo_data  out  DATA_W  assembled record to FIFO data input
- fifo_push  out  1  push strobe to FIFO
- fifo_full  in  1  FIFO full
- fifo_almost_full  in  1  FIFO almost full (≥252 entries)
- host_busy  out  1  registered flow-control flag for the MCU
- tri_count  out  16  triangles pushed, wraps at 2^16
- err_count  out  8  framing errors, saturates at 255

## Operation
- Byte order: byte 0 lands in fifo_data[DATA_W-1 -: 8], byte BYTES-1 in [7:0]. Shift-left register: each accepted byte shifts in at [7:0].
- Byte index counter idx, 0..BYTES-1, 5 bits for default.
- States:
  - IDLE: in_ready=1. Transfer with in_first=1: load byte, idx←1, go COLLECT. Transfer with in_first=0: discard, err_count+1.
  - COLLECT: in_ready=1. Transfer with in_first=0: shift in, idx+1; if this was byte BYTES-1 (idx==BYTES-1 before increment), go PUSH. Transfer with in_first=1: resync: err_count+1, drop partial record, load this byte as byte 0, idx←1, stay COLLECT.
  - PUSH: in_ready=0. fifo_push = !fifo_full (combinational from state and fifo_full). On a cycle with fifo_push=1: tri_count+1, go IDLE. Stays in PUSH indefinitely while fifo_full=1.
- fifo_data holds the complete record unchanged for every PUSH cycle; no change outside shift/load events.
- fifo_push never asserted outside PUSH; never asserted while fifo_full=1.
- host_busy ← fifo_almost_full | (state==PUSH & fifo_full), registered.
- err_count saturates at 255 (no wrap); tri_count wraps 65535→0.
- Requires BYTES ≥ 2.

## Timing
- Reset (rst high at a rising edge): state IDLE, idx 0, fifo_data 0, fifo_push 0, host_busy 0, tri_count 0, err_count 0. in_ready=0 during any cycle rst is high; 1 in first cycle after.
- Reset mid-COLLECT or mid-PUSH: partial/pending record discarded, no push, no err_count increment.
- Latency: last byte accepted at edge N → fifo_push=1 in cycle N+1 (FIFO not full) → state IDLE, in_ready=1 in cycle N+2.
- Peak throughput: one triangle per BYTES+1 cycles (one dead in_ready cycle per record).
- fifo_full rising during PUSH: fifo_push drops same cycle; record held; push completes in first cycle fifo_full=0.
- host_busy lags fifo_almost_full by one cycle.
- in_valid with in_ready=0: byte not consumed; upstream holds it; no error counted.

## Test plan
- Reset then one frame of bytes 0x01..0x1E (first flag on 0x01), fifo_full=0 -> exactly one fifo_push, 31 cycles after first byte, fifo_data = 0x0102…1E, tri_count=1, err_count=0.
- Two back-to-back frames, in_valid held high -> in_ready low exactly one cycle between frames, tri_count=2, both records correct.
- fifo_full=1 when frame completes, released after 10 cycles -> fifo_push=0 for 10 cycles, data stable, single push at release, host_busy=1 one cycle after fifo_full while in PUSH.
- 5 bytes without in_first, then a valid frame -> err_count=5, one correct push; a frame truncated after 12 bytes by a new in_first -> err_count+1, only new frame pushed.
- rst pulsed after 17 bytes of a frame -> no push, counters 0, next full frame pushed correctly.
- 300 frames with err stimulus forcing >255 errors -> err_count=255, tri_count=300.
